// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, with a final sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 div0_q, div0_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_r_q, neg_r_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     rs_q, rs_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign signed_op = ~op_i[0];
    assign a_abs     = (signed_op && rs_val_i[WIDTH-1]) ? -rs_val_i : rs_val_i;
    assign b_abs     = (signed_op && rt_val_i[WIDTH-1]) ? -rt_val_i : rt_val_i;

    // Multiplier sits in the low half of acc and is consumed as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {remainder, quotient}; rem_sh is the remainder after the left shift.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_a_q ? -acc_q : acc_q;
    assign quot_fix = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_a_d  = neg_a_q;
        neg_r_d  = neg_r_q;
        b_d      = b_q;
        rs_d     = rs_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op_i[1];
                    div0_d   = (rt_val_i == '0);
                    neg_a_d  = signed_op & (rs_val_i[WIDTH-1] ^ rt_val_i[WIDTH-1]);
                    neg_r_d  = signed_op & rs_val_i[WIDTH-1];
                    rs_d     = rs_val_i;
                    if (op_i[1]) begin
                        b_d   = b_abs;
                        acc_d = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        b_d   = a_abs;
                        acc_d = {{WIDTH{1'b0}}, b_abs};
                    end
                end else begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            b_q      <= '0;
            rs_q     <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_a_q  <= neg_a_d;
            neg_r_q  <= neg_r_d;
            b_q      <= b_d;
            rs_q     <= rs_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue,
// popped and compared by a monitor on every done pulse.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op),
        .rs_val_i(rs), .rt_val_i(rt), .mthi_i(mthi), .mtlo_i(mtlo),
        .wdata_i(wdata), .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain MIPS arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int qi, ri;
        case (o)
            2'd0: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd3) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = $signed(a) / $signed(b);
                ri = $signed(a) % $signed(b);
                return {32'(ri), 32'(qi)};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h_%h required=no_done", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("result hi=%h lo=%h expected=%h", hi, lo, mon_exp);
                check("result", {hi, lo}, mon_exp);
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Issue one operation and time it; noise injects ignored start/MT traffic.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input bit noise);
        int n;
        int bc;
        if (!b2b) @(negedge clk);
        op = o; rs = a; rt = b; start = 1'b1;
        mthi = noise; mtlo = noise; wdata = $urandom;
        @(posedge clk);
        exp_q.push_back(model(o, a, b));
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs = $urandom; rt = $urandom; op = 2'($urandom);
        n = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (noise && n == 10) begin
                start = 1'b1; op = 2'($urandom); rs = $urandom; rt = $urandom;
            end
            if (noise && (n == 5 || n == 20)) begin
                mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
            end
        end while (!done && n < 100);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("latency", 64'(n), 64'd34);
        check("busy_cycles", 64'(bc), 64'd33);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        #12;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1);
        run_op(2'd3, 32'd100, 32'd7, 1, 0);
        run_op(2'd3, 32'd100, 32'd0, 0, 1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(2'd2, 32'd1234, 32'd0, 0, 0);

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        $display("mt both hi=%h lo=%h", hi, lo);
        check("mt_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
        mthi = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        mthi = 1'b0;
        $display("mthi only hi=%h lo=%h", hi, lo);
        check("mthi_only", {hi, lo}, {32'hA5A5_5A5A, 32'h1234_5678});

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Abort a DIV with reset partway through.
        @(negedge clk);
        op = 2'd2; rs = 32'h7654_3210; rt = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("abort hi=%h lo=%h busy=%0d done=%0d", hi, lo, busy, done);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);
        run_op(2'd0, 32'd5, 32'd6, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative MIPS multiply/divide unit holding the architectural HI and LO registers. It sits in the execute stage directly downstream of the register file and consumes the two read operands, rs_val and rt_val, that the register file presents for MULT/MULTU/DIV/DIVU. It also services MTHI/MTLO writes and continuously drives HI/LO for MFHI/MFLO. Each operation takes a fixed number of cycles, and `busy`/`done` let the hazard logic stall dependent instructions.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation selected by `op`; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  WIDTH  multiplicand or dividend (register-file read port 1).
- `rt_val`  in  WIDTH  multiplier or divisor (register-file read port 2).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress; high in RUN and FIX.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO take a result.

## Operation
- Reset (asynchronous, rst_n=0): state←IDLE, hi=lo=0, busy=0, done=0, iteration counter=0. Asserting reset mid-operation aborts the operation; no partial result is ever written.
- States: IDLE → RUN → FIX → IDLE.
- IDLE:
  - start=1: latch op and the operands; state←RUN; counter←0.
  - Operand conditioning: for MULT/DIV, latch the absolute values and record the result signs.
    - Product sign, and quotient sign for DIV: rs[31]^rt[31].
    - Remainder sign: rs[31].
  - Divisor zero at start flags div0.
  - Priority: start over mthi/mtlo. When start=1, MT writes in the same cycle are dropped.
  - start=0: mthi and mtlo each independently write `wdata`; both may be asserted in the same cycle.
- RUN: one iteration per cycle, exactly 32 iterations, counter 0..31. After iteration 31, state←FIX.
  - Multiply: shift-add. If multiplier LSB=1, add multiplicand into the upper 33 bits of the 64-bit accumulator. Shift the accumulator and multiplier right by 1.
  - Divide: restoring. Shift {rem,quot} left 1. Trial-subtract the divisor from the 33-bit remainder. If the result is non-negative, keep it and set the quotient LSB=1.
- FIX: apply sign correction and write the result, then state←IDLE.
  - Signed ops: two's-complement negate the 64-bit product, quotient, or remainder if its recorded sign is 1.
  - MULT/MULTU: HI←product[63:32], LO←product[31:0].
  - DIV/DIVU: LO←quotient, HI←remainder.
  - div0 (both DIV and DIVU): LO←0xFFFFFFFF, HI←original rs_val. The cycle count is unchanged.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: LO←0x80000000, HI←0. This falls out of the magnitude datapath naturally.
- In RUN/FIX, start, mthi and mtlo are ignored. The hazard unit stalls MFHI/MFLO/MT*/new mult-div while busy=1.
- Operand inputs are not required to stay stable after the start cycle.

## Timing
- Start accepted at edge E0. busy=1 from just after E0.
- Iterations run on edges E1..E32. FIX occurs at edge E33.
- HI/LO are updated at E33; busy=0 and done=1 during the cycle E33–E34.
- Latency: 33 cycles from start edge to result.
- Back-to-back: start may be asserted in the same cycle done=1. It is accepted at E34.
- MTHI/MTLO in IDLE: visible on hi/lo the cycle after the edge.
- done is low at every other time, including after reset.

## Test plan
- **MULTU 0xFFFFFFFF×0xFFFFFFFF:** hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 33 edges after start; busy=1 for exactly 33 cycles.
- **Signed ops:**
  - MULT -3×7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7: lo=14, hi=2.
- **Special cases:**
  - DIVU 100/0: hi=0x00000064, lo=0xFFFFFFFF, same latency.
  - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- **MT writes and priority:**
  - Idle mthi=mtlo=1 with wdata=0x12345678: both registers read 0x12345678 next cycle.
  - start with mthi in the same cycle: mthi dropped; the mult result lands.
  - mtlo during busy: ignored.
- **start pulses mid-operation:** a second start at E10 with different operands is ignored; the result matches the first operation. A start in the done cycle is accepted.
- **Reset abort:** rst_n low at E15 of a DIV clears hi/lo to 0 asynchronously with busy=0 and no done pulse. After release, a fresh MULT 5×6 gives lo=30, hi=0.
